// File: rtl/i2c_cfg_sequencer_if.sv
// i2c_cfg_sequencer_if
// Request/done handshake between the configuration sequencer and the shared
// I2C master.
//   i2c_req    sequencer -> master  transaction request, held until i2c_done
//   i2c_rd     sequencer -> master  1 = read, 0 = write
//   i2c_addr   sequencer -> master  register address
//   i2c_wdata  sequencer -> master  write data (expected data for reads)
//   i2c_done   master -> sequencer  one-cycle pulse ending a transaction
//   i2c_nack   master -> sequencer  qualifies i2c_done: transaction NACKed
//   i2c_rdata  master -> sequencer  read data, valid with i2c_done
// The sequencer connects through the master modport, the I2C engine through
// the slave modport.
interface i2c_cfg_sequencer_if #(
  parameter int REG_ADDR_W = 8,
  parameter int DATA_W     = 8
);
  logic                  i2c_req;
  logic                  i2c_rd;
  logic [REG_ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0]     i2c_wdata;
  logic                  i2c_done;
  logic                  i2c_nack;
  logic [DATA_W-1:0]     i2c_rdata;

  modport master (
    output i2c_req, i2c_rd, i2c_addr, i2c_wdata,
    input  i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rd, i2c_addr, i2c_wdata,
    output i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer
// Walks a combinational register table one entry per step and drives the
// shared I2C master for sensor/codec bring-up. Entry = {op, reg_addr, data}:
// op 00 write, 01 read-verify, 10 delay (data = units of DLY_TICK clocks),
// 11 end of table.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   start       one-cycle pulse, starts the walk (ignored while busy)
//   LUT_INDEX   index presented to the table
//   LUT_DATA    table entry at LUT_INDEX (same cycle)
//   i2c         handshake to the I2C master (master modport)
//   busy        walk in progress
//   cfg_done    sticky, table completed without error
//   cfg_err     sticky, walk aborted
//   err_index   failing entry index, valid with cfg_err
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | latch table entry at LUT_INDEX and decode op
// ISSUE   | present request fields, raise i2c_req
// WAIT    | hold request until i2c_done, judge NACK / read data
// DELAY   | count down the delay entry
// NEXT    | advance LUT_INDEX or finish at the last entry
// DONE    | flag cfg_done, return to IDLE
// ERROR   | flag cfg_err, capture err_index, return to IDLE
module i2c_cfg_sequencer #(
  parameter int REG_ADDR_W = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 8,
  parameter int LUT_SIZE   = 167,
  parameter int MAX_RETRY  = 3,
  parameter int DLY_TICK   = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [IDX_W-1:0]             LUT_INDEX,
  input  logic [2+REG_ADDR_W+DATA_W-1:0] LUT_DATA,
  i2c_cfg_sequencer_if.master          i2c,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic [IDX_W-1:0]             err_index
);

  localparam int ENTRY_W = 2 + REG_ADDR_W + DATA_W;
  // Sized for the largest 8-bit delay count.
  localparam int CNT_W   = $clog2(255 * DLY_TICK + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ent_rd_q, ent_rd_d;
  logic [REG_ADDR_W-1:0] ent_addr_q, ent_addr_d;
  logic [DATA_W-1:0]     ent_data_q, ent_data_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0]      dly_q, dly_d;
  logic                  req_q, req_d;
  logic                  rd_q, rd_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_idx_q, err_idx_d;

  logic [1:0]            lut_op;
  logic [REG_ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0]     lut_data;
  logic [CNT_W-1:0]      dly_load;

  assign lut_op   = LUT_DATA[ENTRY_W-1 -: 2];
  assign lut_addr = LUT_DATA[DATA_W +: REG_ADDR_W];
  assign lut_data = LUT_DATA[DATA_W-1:0];
  assign dly_load = CNT_W'(lut_data) * CNT_W'(DLY_TICK);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_rd_d   = ent_rd_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    retry_d    = retry_q;
    dly_d      = dly_q;
    req_d      = req_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          retry_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ent_rd_d   = lut_op[0];
        ent_addr_d = lut_addr;
        ent_data_d = lut_data;
        case (lut_op)
          2'b00, 2'b01: state_d = S_ISSUE;
          2'b10: begin
            if (lut_data == '0) begin
              state_d = S_NEXT;
            end else begin
              dly_d   = dly_load;
              state_d = S_DELAY;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        rd_d    = ent_rd_q;
        addr_d  = ent_addr_q;
        wdata_d = ent_data_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c.i2c_done) begin
          req_d = 1'b0;
          if (i2c.i2c_nack) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = S_ISSUE;
            end else begin
              state_d = S_ERROR;
            end
          end else if (ent_rd_q && (i2c.i2c_rdata != ent_data_q)) begin
            // Read-back mismatch means wrong part or bad bus; retrying won't help.
            state_d = S_ERROR;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_DELAY: begin
        dly_d = dly_q - CNT_W'(1);
        if (dly_q <= CNT_W'(1)) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_W'(LUT_SIZE - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops i2c_req immediately; the I2C master is not waited for.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ent_rd_q   <= 1'b0;
      ent_addr_q <= '0;
      ent_data_q <= '0;
      retry_q    <= '0;
      dly_q      <= '0;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_rd_q   <= ent_rd_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      retry_q    <= retry_d;
      dly_q      <= dly_d;
      req_q      <= req_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign LUT_INDEX     = idx_q;
  assign i2c.i2c_req   = req_q;
  assign i2c.i2c_rd    = rd_q;
  assign i2c.i2c_addr  = addr_q;
  assign i2c.i2c_wdata = wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign err_index     = err_idx_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
module tb_i2c_cfg_sequencer;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int IW = 8;
  localparam int EW = 2 + AW + DW;
  localparam logic [EW-1:0] END_ENT = {2'b11, 24'h0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT: 16-bit addresses, LUT_SIZE 16 -------------
  logic [EW-1:0] lut_mem [0:255];
  logic [IW-1:0] lut_index;
  logic [EW-1:0] lut_data;
  logic          busy, cfg_done, cfg_err;
  logic [IW-1:0] err_index;

  assign lut_data = lut_mem[lut_index];

  i2c_cfg_sequencer_if #(.REG_ADDR_W(AW), .DATA_W(DW)) bus ();

  i2c_cfg_sequencer #(
    .REG_ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .LUT_SIZE(16),
    .MAX_RETRY(3), .DLY_TICK(10)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .LUT_INDEX(lut_index), .LUT_DATA(lut_data),
    .i2c(bus),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index)
  );

  // I2C master model: answers each request after lat_set cycles.
  // The first nack_first requests since reset are NACKed; reads return rd_val.
  int          nack_first = 0;
  int          lat_set = 2;
  logic [7:0]  rd_val = 8'h00;
  int          req_cnt = 0;
  int          stab_err = 0;
  int          lat = 0;
  bit          act = 1'b0;
  logic        prev_req = 1'b0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;
  logic        last_rd = 1'b0;
  int          rise_cyc [0:7];
  int          fall_cyc [0:7];
  int          fall_n = 0;

  always @(negedge clk) begin
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = rd_val;
    if (rst) begin
      act      = 1'b0;
      prev_req = 1'b0;
      req_cnt  = 0;
      stab_err = 0;
      fall_n   = 0;
    end else begin
      if (prev_req && !bus.i2c_req && fall_n < 8) begin
        fall_cyc[fall_n] = cyc;
        fall_n++;
      end
      if (act) begin
        if (bus.i2c_addr !== last_addr || bus.i2c_wdata !== last_wdata ||
            bus.i2c_rd !== last_rd || bus.i2c_req !== 1'b1)
          stab_err++;
        lat--;
        if (lat == 0) begin
          bus.i2c_done = 1'b1;
          bus.i2c_nack = (req_cnt <= nack_first);
          act = 1'b0;
        end
      end else if (bus.i2c_req) begin
        if (req_cnt < 8) rise_cyc[req_cnt] = cyc;
        req_cnt++;
        last_addr  = bus.i2c_addr;
        last_wdata = bus.i2c_wdata;
        last_rd    = bus.i2c_rd;
        act = 1'b1;
        lat = lat_set;
      end
      prev_req = bus.i2c_req;
    end
  end

  // ---------------- second DUT: LUT_SIZE 3, no end marker -----------------
  logic       start3 = 1'b0;
  logic [7:0] idx3;
  logic [17:0] lut3;
  logic       busy3, done3, err3;
  logic [7:0] eidx3;
  int         cnt3 = 0;
  bit         pend3 = 1'b0;
  logic [7:0] last_addr3 = '0;

  always_comb begin
    case (idx3)
      8'd0:    lut3 = {2'b00, 8'h01, 8'hA1};
      8'd1:    lut3 = {2'b00, 8'h02, 8'hA2};
      8'd2:    lut3 = {2'b00, 8'h03, 8'hA3};
      default: lut3 = {2'b00, 8'hFF, 8'hEE};
    endcase
  end

  i2c_cfg_sequencer_if #(.REG_ADDR_W(8), .DATA_W(8)) bus3 ();

  i2c_cfg_sequencer #(
    .REG_ADDR_W(8), .DATA_W(8), .IDX_W(8), .LUT_SIZE(3),
    .MAX_RETRY(3), .DLY_TICK(10)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .LUT_INDEX(idx3), .LUT_DATA(lut3),
    .i2c(bus3),
    .busy(busy3), .cfg_done(done3), .cfg_err(err3), .err_index(eidx3)
  );

  always @(negedge clk) begin
    bus3.i2c_nack  = 1'b0;
    bus3.i2c_rdata = 8'h00;
    if (rst) begin
      bus3.i2c_done = 1'b0;
      pend3 = 1'b0;
      cnt3  = 0;
    end else if (bus3.i2c_done) begin
      bus3.i2c_done = 1'b0;
    end else if (pend3) begin
      bus3.i2c_done = 1'b1;
      pend3 = 1'b0;
    end else if (bus3.i2c_req) begin
      cnt3++;
      last_addr3 = bus3.i2c_addr;
      pend3 = 1'b1;
    end else begin
      bus3.i2c_done = 1'b0;
    end
  end

  // ---------------- helpers ----------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic apply_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [15:0] a,
                                        input logic [7:0] d);
    return {op, a, d};
  endfunction

  typedef struct {
    string         name;
    logic [EW-1:0] e0, e1, e2, e3;
    int            nack_first;
    logic [7:0]    rd_val;
    int            exp_req;
    bit            exp_done;
    bit            exp_err;
    int            exp_eidx;
    logic [15:0]   exp_addr;
    logic [7:0]    exp_wdata;
    bit            exp_rd;
    int            exp_gap;   // -1: not checked
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 256; k++) lut_mem[k] = END_ENT;

    // Gap: 20 DELAY cycles + NEXT/FETCH of the delay entry + NEXT/FETCH/ISSUE
    // of the following write = 25 cycles with i2c_req low.
    vecs[0] = '{"wr_dly_wr", ent(2'b00, 16'h0012, 8'h80), ent(2'b10, 16'h0000, 8'd2),
                ent(2'b00, 16'h0011, 8'h80), END_ENT,
                0, 8'h00, 2, 1'b1, 1'b0, 0, 16'h0011, 8'h80, 1'b0, 25};
    vecs[1] = '{"rdv_ok", ent(2'b01, 16'h001C, 8'h7F), ent(2'b00, 16'h3008, 8'h82),
                END_ENT, END_ENT,
                0, 8'h7F, 2, 1'b1, 1'b0, 0, 16'h3008, 8'h82, 1'b0, -1};
    vecs[2] = '{"rdv_bad", ent(2'b00, 16'h3008, 8'h82), ent(2'b01, 16'h001C, 8'h7F),
                END_ENT, END_ENT,
                0, 8'h7E, 2, 1'b0, 1'b1, 1, 16'h001C, 8'h7F, 1'b1, -1};
    vecs[3] = '{"nack2", ent(2'b00, 16'h0040, 8'h11), ent(2'b00, 16'h0041, 8'h22),
                END_ENT, END_ENT,
                2, 8'h00, 4, 1'b1, 1'b0, 0, 16'h0041, 8'h22, 1'b0, -1};
    vecs[4] = '{"nack_all", ent(2'b00, 16'h0040, 8'h11), ent(2'b00, 16'h0041, 8'h22),
                END_ENT, END_ENT,
                99, 8'h00, 4, 1'b0, 1'b1, 0, 16'h0040, 8'h11, 1'b0, -1};
    vecs[5] = '{"dly0", ent(2'b10, 16'h0000, 8'd0), ent(2'b01, 16'h0A0B, 8'h5A),
                END_ENT, END_ENT,
                0, 8'h5A, 1, 1'b1, 1'b0, 0, 16'h0A0B, 8'h5A, 1'b1, -1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_index", 32'(lut_index), 32'd0);
    chk("rst_req", 32'(bus.i2c_req), 32'd0);
    chk("rst_rd", 32'(bus.i2c_rd), 32'd0);
    chk("rst_addr", 32'(bus.i2c_addr), 32'd0);
    chk("rst_wdata", 32'(bus.i2c_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_eidx", 32'(err_index), 32'd0);
    rst = 1'b0;

    // Table-driven walks
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 256; k++) lut_mem[k] = END_ENT;
      lut_mem[0] = vecs[i].e0;
      lut_mem[1] = vecs[i].e1;
      lut_mem[2] = vecs[i].e2;
      lut_mem[3] = vecs[i].e3;
      nack_first = vecs[i].nack_first;
      rd_val     = vecs[i].rd_val;
      lat_set    = 2;
      apply_rst();
      pulse_start();
      wait_idle(vecs[i].name);
      repeat (10) @(negedge clk);
      chk({vecs[i].name, "_done"}, 32'(cfg_done), 32'(vecs[i].exp_done));
      chk({vecs[i].name, "_err"}, 32'(cfg_err), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_nreq"}, 32'(req_cnt), 32'(vecs[i].exp_req));
      chk({vecs[i].name, "_addr"}, 32'(last_addr), 32'(vecs[i].exp_addr));
      chk({vecs[i].name, "_wdata"}, 32'(last_wdata), 32'(vecs[i].exp_wdata));
      chk({vecs[i].name, "_rd"}, 32'(last_rd), 32'(vecs[i].exp_rd));
      chk({vecs[i].name, "_stable"}, 32'(stab_err), 32'd0);
      chk({vecs[i].name, "_req_low"}, 32'(bus.i2c_req), 32'd0);
      if (vecs[i].exp_err)
        chk({vecs[i].name, "_eidx"}, 32'(err_index), 32'(vecs[i].exp_eidx));
      if (vecs[i].exp_gap >= 0)
        chk({vecs[i].name, "_gap"}, 32'(rise_cyc[1] - fall_cyc[0]), 32'(vecs[i].exp_gap));
    end

    // start -> first i2c_req latency
    for (int k = 0; k < 256; k++) lut_mem[k] = END_ENT;
    lut_mem[0] = ent(2'b00, 16'h0012, 8'h80);
    nack_first = 0;
    apply_rst();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!bus.i2c_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency", 32'(n), 32'd3);
    wait_idle("latency");

    // rst during WAIT, restart from 0, start while busy ignored
    lut_mem[0] = ent(2'b00, 16'h0021, 8'h01);
    lut_mem[1] = ent(2'b00, 16'h0022, 8'h02);
    lut_mem[2] = END_ENT;
    lat_set = 30;
    apply_rst();
    pulse_start();
    n = 0;
    while (!(req_cnt == 2 && bus.i2c_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midwalk_reached", 32'(lut_index), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(bus.i2c_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_index", 32'(lut_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat_set = 2;
    pulse_start();
    n = 0;
    while (!bus.i2c_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("restart_addr", 32'(last_addr), 32'h0021);
    pulse_start();
    wait_idle("restart");
    repeat (10) @(negedge clk);
    chk("restart_nreq", 32'(req_cnt), 32'd2);
    chk("restart_done", 32'(cfg_done), 32'd1);
    chk("restart_index", 32'(lut_index), 32'd2);

    // read-verify failure at index 2, then a fresh start clears cfg_err
    lut_mem[0] = ent(2'b00, 16'h0030, 8'h01);
    lut_mem[1] = ent(2'b00, 16'h0031, 8'h02);
    lut_mem[2] = ent(2'b01, 16'h001C, 8'h7F);
    lut_mem[3] = END_ENT;
    rd_val = 8'h00;
    apply_rst();
    pulse_start();
    wait_idle("err2");
    chk("err2_err", 32'(cfg_err), 32'd1);
    chk("err2_eidx", 32'(err_index), 32'd2);
    chk("err2_done", 32'(cfg_done), 32'd0);
    rd_val = 8'h7F;
    pulse_start();
    wait_idle("retry_ok");
    chk("rerun_err", 32'(cfg_err), 32'd0);
    chk("rerun_done", 32'(cfg_done), 32'd1);

    // LUT_SIZE=3 with no end marker
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (busy3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("lut3_idle", 32'(busy3), 32'd0);
    chk("lut3_nreq", 32'(cnt3), 32'd3);
    chk("lut3_index", 32'(idx3), 32'd2);
    chk("lut3_done", 32'(done3), 32'd1);
    chk("lut3_err", 32'(err3), 32'd0);
    chk("lut3_last_addr", 32'(last_addr3), 32'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
